// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan motor sequencer: stage and ramp-state encodings,
// default duty table and the auto-off timer presets.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        STAGE_OFF = 2'd0,
        STAGE_1   = 2'd1,
        STAGE_2   = 2'd2,
        STAGE_3   = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_HOLD      = 2'd3
    } ramp_state_e;

    localparam int DEF_CNT_W     = 10;
    localparam int DEF_DUTY_S1   = 300;
    localparam int DEF_DUTY_S2   = 600;
    localparam int DEF_DUTY_S3   = 900;
    localparam int DEF_RAMP_STEP = 16;
    localparam int DEF_TIMER_W   = 9;

    localparam int PRESET_A_SEC = 60;
    localparam int PRESET_B_SEC = 180;
    localparam int PRESET_C_SEC = 300;

    // Preset index 0 means "timer off"; indices 1..3 walk through the presets.
    function automatic int unsigned timer_preset(input logic [1:0] idx);
        case (idx)
            2'd1:    return PRESET_A_SEC;
            2'd2:    return PRESET_B_SEC;
            2'd3:    return PRESET_C_SEC;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM counter advanced by a tick strobe; the output is registered
// and high while the counter is below the requested duty.
module fan_pwm_gen #(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm
);

    logic [CNT_W-1:0] cnt;

    // Counter wraps naturally from all-ones back to zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt   <= '0;
            o_pwm <= 1'b0;
        end else begin
            if (i_tick) cnt <= cnt + CNT_W'(1);
            o_pwm <= (cnt < i_duty);
        end
    end

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan motor sequencer: captures stage requests, soft-ramps the PWM duty toward the
// stage level and drives the motor PWM. Optional auto-off timer under FAN_AUTO_OFF_EN.
module fan_ramp_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DUTY_S1   = DEF_DUTY_S1,
    parameter int DUTY_S2   = DEF_DUTY_S2,
    parameter int DUTY_S3   = DEF_DUTY_S3,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int TIMER_W   = DEF_TIMER_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pwm_tick,
    input  logic               i_ramp_tick,
    input  logic               i_req_valid,
    input  logic [1:0]         i_stage_req,
    input  logic               i_timer_btn,
    input  logic               i_sec_tick,
    output logic               o_motor,
    output logic [1:0]         o_stage,
    output logic [CNT_W-1:0]   o_duty,
    output logic               o_ramping,
    output logic [TIMER_W-1:0] o_timer_remain
);

    localparam int AW = CNT_W + 1;

    ramp_state_e        state, state_nxt;
    logic [CNT_W-1:0]   duty, duty_nxt;
    logic [1:0]         stage;
    logic [CNT_W-1:0]   target, req_target;
    logic               req_any;
    logic [1:0]         req_stage;
    logic               timer_expire;
    logic [TIMER_W-1:0] remain;
    logic [AW-1:0]      up_sum, dn_diff;
    logic [CNT_W-1:0]   up_val, dn_val;

    function automatic logic [CNT_W-1:0] stage_duty(input logic [1:0] s);
        case (s)
            STAGE_1: return CNT_W'(DUTY_S1);
            STAGE_2: return CNT_W'(DUTY_S2);
            STAGE_3: return CNT_W'(DUTY_S3);
            default: return '0;
        endcase
    endfunction

`ifdef FAN_AUTO_OFF_EN
    logic [1:0] preset_idx;
    logic [1:0] idx_nxt;
    logic       ext_off;
    logic       btn_load;

    assign idx_nxt  = preset_idx + 2'd1;
    assign ext_off  = i_req_valid && (i_stage_req == STAGE_OFF);
    assign btn_load = i_timer_btn && (stage != STAGE_OFF) && !ext_off;
    assign timer_expire = i_sec_tick && (remain == TIMER_W'(1)) && !btn_load && !ext_off;

    // Turning the fan off externally also cancels any pending countdown.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            remain     <= '0;
            preset_idx <= 2'd0;
        end else if (ext_off) begin
            remain     <= '0;
            preset_idx <= 2'd0;
        end else if (btn_load) begin
            preset_idx <= idx_nxt;
            remain     <= TIMER_W'(timer_preset(idx_nxt));
        end else if (i_sec_tick && (remain != '0)) begin
            remain <= remain - TIMER_W'(1);
            if (remain == TIMER_W'(1)) preset_idx <= 2'd0;
        end
    end
`else
    logic unused_timer_inputs;
    assign unused_timer_inputs = i_timer_btn ^ i_sec_tick;
    assign timer_expire = 1'b0;
    assign remain       = '0;
`endif

    // External requests take priority over an auto-off expiry in the same cycle.
    always_comb begin
        req_any   = i_req_valid;
        req_stage = i_stage_req;
        if (!i_req_valid && timer_expire) begin
            req_any   = 1'b1;
            req_stage = STAGE_OFF;
        end
    end

    assign target     = stage_duty(stage);
    assign req_target = stage_duty(req_stage);

    // Steps are computed one bit wider so the clamps see true over/underflow.
    assign up_sum  = {1'b0, duty} + AW'(RAMP_STEP);
    assign dn_diff = {1'b0, duty} - AW'(RAMP_STEP);
    assign up_val  = (up_sum > {1'b0, target}) ? target : up_sum[CNT_W-1:0];
    assign dn_val  = (dn_diff[CNT_W] || (dn_diff[CNT_W-1:0] < target)) ? target
                                                                        : dn_diff[CNT_W-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            duty  <= '0;
            stage <= STAGE_OFF;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            if (req_any) stage <= req_stage;
        end
    end

    // A request picks the direction from the new target; the step itself waits a cycle.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        if (req_any) begin
            if (req_target > duty)
                state_nxt = ST_RAMP_UP;
            else if (req_target < duty)
                state_nxt = ST_RAMP_DOWN;
            else
                state_nxt = (req_target == '0) ? ST_IDLE : ST_HOLD;
        end else if (i_ramp_tick) begin
            case (state)
                ST_RAMP_UP: begin
                    duty_nxt = up_val;
                    if (up_val == target) state_nxt = ST_HOLD;
                end
                ST_RAMP_DOWN: begin
                    duty_nxt = dn_val;
                    if (dn_val == target) state_nxt = (target == '0) ? ST_IDLE : ST_HOLD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_ramping = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
    end

    fan_pwm_gen #(
        .CNT_W (CNT_W)
    ) u_pwm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (i_pwm_tick),
        .i_duty  (duty),
        .o_pwm   (o_motor)
    );

    assign o_stage        = stage;
    assign o_duty         = duty;
    assign o_timer_remain = remain;

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Directed bench for fan_ramp_ctrl: ramp up/down, retarget, request/tick collision,
// async reset, PWM duty count and (with FAN_AUTO_OFF_EN) the auto-off timer.
module tb_fan_ramp_ctrl;

    localparam int CNT_W   = 10;
    localparam int TIMER_W = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pwm_tick = 1'b0;
    logic               ramp_tick = 1'b0;
    logic               req_valid = 1'b0;
    logic [1:0]         stage_req = 2'd0;
    logic               timer_btn = 1'b0;
    logic               sec_tick = 1'b0;
    logic               motor;
    logic [1:0]         stage;
    logic [CNT_W-1:0]   duty;
    logic               ramping;
    logic [TIMER_W-1:0] remain;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fan_ramp_ctrl dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_pwm_tick     (pwm_tick),
        .i_ramp_tick    (ramp_tick),
        .i_req_valid    (req_valid),
        .i_stage_req    (stage_req),
        .i_timer_btn    (timer_btn),
        .i_sec_tick     (sec_tick),
        .o_motor        (motor),
        .o_stage        (stage),
        .o_duty         (duty),
        .o_ramping      (ramping),
        .o_timer_remain (remain)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_req(input logic [1:0] s);
        req_valid = 1'b1;
        stage_req = s;
        step();
        req_valid = 1'b0;
    endtask

    task automatic pulse_ramp();
        ramp_tick = 1'b1;
        step();
        ramp_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (duty !== '0)    begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty); end
        checks++; if (stage !== 2'd0) begin failures++; $display("FAIL reset_stage got=%0d exp=0", stage); end
        checks++; if (motor !== 1'b0) begin failures++; $display("FAIL reset_motor got=%0b exp=0", motor); end
        checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL reset_ramping got=%0b exp=0", ramping); end
        checks++; if (remain !== '0)  begin failures++; $display("FAIL reset_remain got=%0d exp=0", remain); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ramp_up();
        int exp;
        do_reset();
        pulse_req(2'd2);
        checks++; if (stage !== 2'd2 || duty !== '0 || ramping !== 1'b1)
            begin failures++; $display("FAIL up_start stage=%0d duty=%0d ramping=%0b exp 2/0/1", stage, duty, ramping); end
        for (int k = 1; k <= 38; k++) begin
            pulse_ramp();
            exp = (16 * k > 600) ? 600 : 16 * k;
            checks++; if (duty !== CNT_W'(exp))
                begin failures++; $display("FAIL up_duty tick=%0d got=%0d exp=%0d", k, duty, exp); end
            checks++; if (ramping !== (k < 38))
                begin failures++; $display("FAIL up_ramping tick=%0d got=%0b exp=%0b", k, ramping, (k < 38)); end
        end
        pulse_ramp();
        checks++; if (duty !== 10'd600) begin failures++; $display("FAIL up_hold got=%0d exp=600", duty); end
    endtask

    task automatic test_ramp_down();
        int exp;
        int highs;
        pulse_req(2'd3);
        for (int k = 1; k <= 19; k++) pulse_ramp();
        checks++; if (duty !== 10'd900 || ramping !== 1'b0)
            begin failures++; $display("FAIL s3_hold duty=%0d ramping=%0b exp 900/0", duty, ramping); end
        pulse_req(2'd1);
        checks++; if (ramping !== 1'b1) begin failures++; $display("FAIL dn_start ramping=%0b exp=1", ramping); end
        for (int k = 1; k <= 38; k++) begin
            pulse_ramp();
            exp = (900 - 16 * k < 300) ? 300 : 900 - 16 * k;
            checks++; if (duty !== CNT_W'(exp))
                begin failures++; $display("FAIL dn_duty tick=%0d got=%0d exp=%0d", k, duty, exp); end
        end
        checks++; if (ramping !== 1'b0 || stage !== 2'd1)
            begin failures++; $display("FAIL dn_hold ramping=%0b stage=%0d exp 0/1", ramping, stage); end
        pulse_req(2'd0);
        for (int k = 1; k <= 19; k++) pulse_ramp();
        checks++; if (duty !== '0 || ramping !== 1'b0 || stage !== 2'd0)
            begin failures++; $display("FAIL off_idle duty=%0d ramping=%0b stage=%0d exp 0/0/0", duty, ramping, stage); end
        step();
        highs = 0;
        pwm_tick = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (motor === 1'b1) highs++;
        end
        pwm_tick = 1'b0;
        checks++; if (highs != 0) begin failures++; $display("FAIL off_motor highs=%0d exp=0", highs); end
    endtask

    task automatic test_retarget();
        int exp;
        do_reset();
        pulse_req(2'd3);
        for (int k = 1; k <= 25; k++) pulse_ramp();
        checks++; if (duty !== 10'd400 || ramping !== 1'b1)
            begin failures++; $display("FAIL rt_mid duty=%0d ramping=%0b exp 400/1", duty, ramping); end
        pulse_req(2'd1);
        checks++; if (stage !== 2'd1 || duty !== 10'd400)
            begin failures++; $display("FAIL rt_req stage=%0d duty=%0d exp 1/400", stage, duty); end
        for (int k = 1; k <= 7; k++) begin
            pulse_ramp();
            exp = (400 - 16 * k < 300) ? 300 : 400 - 16 * k;
            checks++; if (duty !== CNT_W'(exp))
                begin failures++; $display("FAIL rt_duty tick=%0d got=%0d exp=%0d", k, duty, exp); end
        end
        checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL rt_hold ramping=%0b exp=0", ramping); end
        pulse_ramp();
        checks++; if (duty !== 10'd300) begin failures++; $display("FAIL rt_stay got=%0d exp=300", duty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_req(2'd2);
        for (int k = 1; k <= 5; k++) pulse_ramp();
        checks++; if (duty !== 10'd80) begin failures++; $display("FAIL bb_pre got=%0d exp=80", duty); end
        req_valid = 1'b1;
        stage_req = 2'd3;
        ramp_tick = 1'b1;
        step();
        req_valid = 1'b0;
        ramp_tick = 1'b0;
        checks++; if (duty !== 10'd80 || stage !== 2'd3)
            begin failures++; $display("FAIL bb_collide duty=%0d stage=%0d exp 80/3", duty, stage); end
        pulse_ramp();
        checks++; if (duty !== 10'd96) begin failures++; $display("FAIL bb_next got=%0d exp=96", duty); end
        checks++; if (motor !== 1'b1) begin failures++; $display("FAIL bb_motor_on got=%0b exp=1", motor); end
        rst = 1'b1;
        #1;
        checks++; if (duty !== '0 || stage !== 2'd0 || motor !== 1'b0 || ramping !== 1'b0)
            begin failures++; $display("FAIL async_reset duty=%0d stage=%0d motor=%0b ramping=%0b exp all 0",
                                       duty, stage, motor, ramping); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_pwm();
        int highs;
        int first_low;
        do_reset();
        pulse_req(2'd1);
        for (int k = 1; k <= 19; k++) pulse_ramp();
        checks++; if (duty !== 10'd300) begin failures++; $display("FAIL pwm_duty got=%0d exp=300", duty); end
        highs = 0;
        first_low = 0;
        pwm_tick = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            step();
            if (motor === 1'b1) highs++;
            else if (first_low == 0) first_low = k;
        end
        checks++; if (highs != 300) begin failures++; $display("FAIL pwm_period1 highs=%0d exp=300", highs); end
        checks++; if (first_low != 301) begin failures++; $display("FAIL pwm_edge first_low=%0d exp=301", first_low); end
        step();
        checks++; if (motor !== 1'b1) begin failures++; $display("FAIL pwm_wrap got=%0b exp=1", motor); end
        highs = 1;
        for (int k = 2; k <= 1024; k++) begin
            step();
            if (motor === 1'b1) highs++;
        end
        pwm_tick = 1'b0;
        checks++; if (highs != 300) begin failures++; $display("FAIL pwm_period2 highs=%0d exp=300", highs); end
    endtask

    task automatic test_timer();
        do_reset();
        pulse_req(2'd1);
        for (int k = 1; k <= 19; k++) pulse_ramp();
        timer_btn = 1'b1; step(); timer_btn = 1'b0;
`ifdef FAN_AUTO_OFF_EN
        checks++; if (remain !== 9'd60) begin failures++; $display("FAIL tmr_btn1 got=%0d exp=60", remain); end
`else
        checks++; if (remain !== '0) begin failures++; $display("FAIL tmr_off_btn got=%0d exp=0", remain); end
`endif
        timer_btn = 1'b1; step(); timer_btn = 1'b0;
        sec_tick = 1'b1;
        for (int k = 1; k <= 179; k++) step();
        sec_tick = 1'b0;
`ifdef FAN_AUTO_OFF_EN
        checks++; if (remain !== 9'd1 || stage !== 2'd1)
            begin failures++; $display("FAIL tmr_count remain=%0d stage=%0d exp 1/1", remain, stage); end
        sec_tick = 1'b1; step(); sec_tick = 1'b0;
        checks++; if (remain !== '0 || stage !== 2'd0 || ramping !== 1'b1)
            begin failures++; $display("FAIL tmr_expire remain=%0d stage=%0d ramping=%0b exp 0/0/1", remain, stage, ramping); end
        for (int k = 1; k <= 19; k++) pulse_ramp();
        checks++; if (duty !== '0 || ramping !== 1'b0)
            begin failures++; $display("FAIL tmr_rampdown duty=%0d ramping=%0b exp 0/0", duty, ramping); end
        timer_btn = 1'b1; step(); timer_btn = 1'b0;
        checks++; if (remain !== '0) begin failures++; $display("FAIL tmr_btn_off got=%0d exp=0", remain); end
`else
        checks++; if (remain !== '0 || stage !== 2'd1 || duty !== 10'd300)
            begin failures++; $display("FAIL tmr_disabled remain=%0d stage=%0d duty=%0d exp 0/1/300", remain, stage, duty); end
`endif
    endtask

    initial begin
        step();
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_retarget();
        test_back_to_back();
        test_pwm();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
